// File: rtl/switch_debounce_pkg.sv
// -----------------------------------------------------------------------------
// switch_debounce_pkg
//   Shared helpers for the switch debouncer slice. No shared types: each
//   module derives its own register widths from its parameters, using
//   width_of() so that a degenerate parameter never yields a zero-width vector.
// -----------------------------------------------------------------------------
package switch_debounce_pkg;

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int width_of(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/switch_debounce_if.sv
// -----------------------------------------------------------------------------
// switch_debounce_if
//   Bus between the debouncer and its neighbours.
//     io_ena   enable, gates the sample prescaler only
//     io_in    raw asynchronous switch pins
//     io_out   debounced level bus
//     io_rise  one-cycle pulse per bit on a debounced 0->1 transition
//     io_fall  one-cycle pulse per bit on a debounced 1->0 transition
//     io_tick  sample prescaler tick
//   master: the side that drives pins/enable and consumes the clean bus.
//   slave : the debouncer itself.
// -----------------------------------------------------------------------------
interface switch_debounce_if #(
   parameter int WIDTH = 8
);
   logic             io_ena;
   logic [WIDTH-1:0] io_in;
   logic [WIDTH-1:0] io_out;
   logic [WIDTH-1:0] io_rise;
   logic [WIDTH-1:0] io_fall;
   logic             io_tick;

   modport master (
      output io_ena, io_in,
      input  io_out, io_rise, io_fall, io_tick
   );

   modport slave (
      input  io_ena, io_in,
      output io_out, io_rise, io_fall, io_tick
   );
endinterface

// File: rtl/switch_debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
//   One switch channel: two-flop synchroniser, stability counter, debounced
//   level and registered rise/fall pulses.
//     clock   system clock
//     reset   synchronous, active-high reset
//     tick_i  shared sample tick from the prescaler
//     raw_i   raw asynchronous switch pin
//     out_o   debounced level
//     rise_o  high in the first cycle out_o reads 1
//     fall_o  high in the first cycle out_o reads 0
// -----------------------------------------------------------------------------
module debounce_bit
   import switch_debounce_pkg::*;
#(
   parameter int STABLE_TICKS = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic tick_i,
   input  logic raw_i,
   output logic out_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int              CW       = width_of(STABLE_TICKS + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_TICKS - 1);

   logic          sync1_q, sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          out_q, out_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      cnt_d  = cnt_q;
      out_d  = out_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (sync2_q == out_q) begin
         // Input agrees with the output: any glitch restarts the window.
         cnt_d = '0;
      end else if (tick_i) begin
         if (cnt_q == CNT_LAST) begin
            out_d  = sync2_q;
            cnt_d  = '0;
            rise_d = sync2_q;
            fall_d = ~sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign out_o  = out_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
//   Conditions raw switch pins for the seven-segment controller: a shared
//   sample prescaler plus WIDTH independent debounce channels.
//     clock   system clock
//     reset   synchronous, active-high reset
//     bus     switch_debounce_if slave port (io_ena, io_in in;
//             io_out, io_rise, io_fall, io_tick out)
// -----------------------------------------------------------------------------
module switch_debounce
   import switch_debounce_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int TICK_DIV     = 1000,
   parameter int STABLE_TICKS = 4
) (
   input logic               clock,
   input logic               reset,
   switch_debounce_if.slave  bus
);

   localparam int            PW       = width_of(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0]    pre_q, pre_d;
   logic             tick;
   logic [WIDTH-1:0] out_w, rise_w, fall_w;

   // Prescaler only advances while enabled, so a disabled block never ticks.
   always_comb begin
      pre_d = pre_q;
      if (bus.io_ena) begin
         pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   assign tick = (pre_q == PRE_LAST) && bus.io_ena;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      debounce_bit #(
         .STABLE_TICKS (STABLE_TICKS)
      ) u_bit (
         .clock  (clock),
         .reset  (reset),
         .tick_i (tick),
         .raw_i  (bus.io_in[g]),
         .out_o  (out_w[g]),
         .rise_o (rise_w[g]),
         .fall_o (fall_w[g])
      );
   end

   assign bus.io_out  = out_w;
   assign bus.io_rise = rise_w;
   assign bus.io_fall = fall_w;
   assign bus.io_tick = tick;

endmodule

// File: tb/tb_switch_debounce.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce
//   Directed bench for switch_debounce with TICK_DIV=4, STABLE_TICKS=3.
//   A table of {enable, input, hold cycles, expected level, expected pulses}
//   records covers steady-state transitions; hand-written sequences cover
//   reset, latency window, bounce, enable gating and reset mid-window.
// -----------------------------------------------------------------------------
module tb_switch_debounce;

   localparam int WIDTH        = 8;
   localparam int TICK_DIV     = 4;
   localparam int STABLE_TICKS = 3;

   logic clock = 1'b0;
   logic reset;

   switch_debounce_if #(.WIDTH(WIDTH)) bus ();

   switch_debounce #(
      .WIDTH        (WIDTH),
      .TICK_DIV     (TICK_DIV),
      .STABLE_TICKS (STABLE_TICKS)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic             ena;
      logic [WIDTH-1:0] in;
      int               cycles;
      logic [WIDTH-1:0] exp_out;
      logic [WIDTH-1:0] exp_rise;   // OR of io_rise over the hold
      logic [WIDTH-1:0] exp_fall;   // OR of io_fall over the hold
   } vec_t;

   vec_t vecs [8];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Apply inputs for a number of cycles, then check level and pulse history.
   task automatic run_vec(input string name, input logic ena,
                          input logic [WIDTH-1:0] in, input int cycles,
                          input logic [WIDTH-1:0] exp_out,
                          input logic [WIDTH-1:0] exp_rise,
                          input logic [WIDTH-1:0] exp_fall);
      logic [WIDTH-1:0] rise_acc, fall_acc, both_acc;
      rise_acc = '0;
      fall_acc = '0;
      both_acc = '0;
      bus.io_ena = ena;
      bus.io_in  = in;
      for (int c = 0; c < cycles; c++) begin
         step();
         rise_acc |= bus.io_rise;
         fall_acc |= bus.io_fall;
         both_acc |= bus.io_rise & bus.io_fall;
      end
      check({name, "_out"},     32'(bus.io_out), 32'(exp_out));
      check({name, "_rise"},    32'(rise_acc),   32'(exp_rise));
      check({name, "_fall"},    32'(fall_acc),   32'(exp_fall));
      check({name, "_overlap"}, 32'(both_acc),   32'd0);
   endtask

   initial begin
      int lat;
      int pulses;
      logic [WIDTH-1:0] seen;
      logic tick_seen;

      // Steady-state table; starts with io_out = 8'h01 after the clean step.
      vecs[0] = '{1'b1, 8'h00, 20, 8'h00, 8'h00, 8'h01};  // release bit 0
      vecs[1] = '{1'b1, 8'hA5, 20, 8'hA5, 8'hA5, 8'h00};  // multi-bit rise
      vecs[2] = '{1'b1, 8'h00, 20, 8'h00, 8'h00, 8'hA5};  // multi-bit fall
      vecs[3] = '{1'b1, 8'h0F,  3, 8'h00, 8'h00, 8'h00};  // too short to flip
      vecs[4] = '{1'b1, 8'h00, 20, 8'h00, 8'h00, 8'h00};  // glitch forgotten
      vecs[5] = '{1'b1, 8'hFF, 20, 8'hFF, 8'hFF, 8'h00};  // all bits rise
      vecs[6] = '{1'b1, 8'hFF, 10, 8'hFF, 8'h00, 8'h00};  // steady, quiet
      vecs[7] = '{1'b1, 8'h00, 20, 8'h00, 8'h00, 8'hFF};  // all bits fall

      // ---- reset with all pins high ----
      reset      = 1'b1;
      bus.io_ena = 1'b0;
      bus.io_in  = 8'hFF;
      for (int c = 0; c < 4; c++) begin
         step();
         check("reset_out",  32'(bus.io_out),  32'd0);
         check("reset_rise", 32'(bus.io_rise), 32'd0);
         check("reset_fall", 32'(bus.io_fall), 32'd0);
      end
      reset = 1'b0;
      step();
      check("post_reset_out",  32'(bus.io_out),  32'd0);
      check("post_reset_rise", 32'(bus.io_rise), 32'd0);
      check("post_reset_fall", 32'(bus.io_fall), 32'd0);
      check("post_reset_tick", 32'(bus.io_tick), 32'd0);
      bus.io_in = 8'h00;
      for (int c = 0; c < 4; c++) step();

      // ---- clean step on bit 0: rise 11..14 cycles after the change ----
      bus.io_ena = 1'b1;
      bus.io_in  = 8'h01;
      lat = 0;
      for (int c = 1; c <= 40 && lat == 0; c++) begin
         step();
         if (bus.io_rise[0]) lat = c;
      end
      check("step_latency_in_window", 32'(lat >= 11 && lat <= 14), 32'd1);
      check("step_rise_bits", 32'(bus.io_rise), 32'h01);
      check("step_out",       32'(bus.io_out),  32'h01);
      step();
      check("step_rise_single", 32'(bus.io_rise), 32'h00);
      check("step_out_held",    32'(bus.io_out),  32'h01);

      // ---- table-driven steady-state transitions ----
      for (int v = 0; v < 8; v++) begin
         run_vec($sformatf("vec%0d", v), vecs[v].ena, vecs[v].in,
                 vecs[v].cycles, vecs[v].exp_out, vecs[v].exp_rise,
                 vecs[v].exp_fall);
      end

      // ---- bounce on bit 3: toggles every 3 cycles, then held high ----
      seen   = '0;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         bus.io_in = ((c / 3) % 2 == 0) ? 8'h08 : 8'h00;
         step();
         seen |= bus.io_out | bus.io_rise;
      end
      check("bounce_no_change", 32'(seen), 32'h00);
      bus.io_in = 8'h08;
      for (int c = 0; c < 30; c++) begin
         step();
         if (bus.io_rise[3]) pulses++;
      end
      check("bounce_one_rise", 32'(pulses),     32'd1);
      check("bounce_out",      32'(bus.io_out), 32'h08);

      // ---- enable gating on bit 5 ----
      bus.io_ena = 1'b0;
      bus.io_in  = 8'h28;
      seen       = '0;
      tick_seen  = 1'b0;
      for (int c = 0; c < 100; c++) begin
         step();
         seen      |= bus.io_out ^ 8'h08;
         tick_seen |= bus.io_tick;
      end
      check("gate_out_frozen", 32'(seen),      32'h00);
      check("gate_no_tick",    32'(tick_seen), 32'd0);
      bus.io_ena = 1'b1;
      lat = 0;
      for (int c = 1; c <= 12 && lat == 0; c++) begin
         step();
         if (bus.io_out[5]) lat = c;
      end
      check("gate_flip_within_12", 32'(lat != 0), 32'd1);
      check("gate_out", 32'(bus.io_out), 32'h28);

      // ---- simultaneous multi-bit step, then reset mid-window ----
      run_vec("clear", 1'b1, 8'h00, 20, 8'h00, 8'h00, 8'h28);
      bus.io_in = 8'hA5;
      lat = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         step();
         if (bus.io_rise != 8'h00) lat = c;
      end
      check("multi_rise_same_cycle", 32'(bus.io_rise), 32'hA5);
      check("multi_out_same_cycle",  32'(bus.io_out),  32'hA5);
      step();
      check("multi_rise_single", 32'(bus.io_rise), 32'h00);

      bus.io_in = 8'h00;
      for (int c = 0; c < 6; c++) step();
      check("midwin_out_held", 32'(bus.io_out), 32'hA5);
      reset = 1'b1;
      step();
      check("midwin_reset_out",  32'(bus.io_out),  32'h00);
      check("midwin_reset_rise", 32'(bus.io_rise), 32'h00);
      check("midwin_reset_fall", 32'(bus.io_fall), 32'h00);
      reset = 1'b0;
      run_vec("after_reset_quiet", 1'b1, 8'h00, 20, 8'h00, 8'h00, 8'h00);
      run_vec("redebounce",        1'b1, 8'hA5, 20, 8'hA5, 8'hA5, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
